butterfly_pipe: RTL

- Parametrised, pipelined radix-2 DIT complex butterfly: X = A + B·W, Y = A − B·W.
- Successor to the combinational 32-bit butterfly. Adds generic data/twiddle widths, Q-format rounding, per-sample forward/inverse mode, optional /2 scaling, valid/ready handshake with back-pressure, tag passthrough and a sticky overflow flag.
- Sits between the FFT sample memory and the stage controller.

---
 rtl/bfly_pkg.sv | 37 +++
 rtl/bfly_cmul.sv | 77 +++++++
 rtl/butterfly_pipe.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bfly_pkg.sv
// Shared constants, the complex sample type and width-generic rounding/saturation helpers
// for the butterfly pipeline.
package bfly_pkg;

   localparam int unsigned LATENCY = 4;
   localparam int unsigned MAXW    = 128;

   typedef logic signed [MAXW-1:0] wide_t;

   typedef struct packed {
      wide_t re;
      wide_t im;
   } cplx_t;

   // Round half-up then arithmetic shift right by f.
   function automatic wide_t round_shr(input wide_t v, input int unsigned f);
      wide_t half;
      if (f == 0) return v;
      half = wide_t'(1) <<< (f - 1);
      return (v + half) >>> f;
   endfunction

   function automatic logic fits(input wide_t v, input int unsigned w);
      wide_t lim;
      lim = wide_t'(1) <<< (w - 1);
      return (v < lim) && (v >= -lim);
   endfunction

   // With sat clear the caller keeps the low w bits, which is the wrap behaviour.
   function automatic wide_t reduce(input wide_t v, input int unsigned w, input logic sat);
      wide_t lim;
      lim = wide_t'(1) <<< (w - 1);
      if (!sat || fits(v, w)) return v;
      return v[MAXW-1] ? -lim : lim - wide_t'(1);
   endfunction

endpackage

// File: rtl/bfly_cmul.sv
// Complex twiddle multiply T = B*W (or B*conj(W)) over two pipeline stages with
// Q-format round-half-up; all registers advance only when en is high.
module bfly_cmul
   import bfly_pkg::*;
#(
   parameter int unsigned DW = 32,
   parameter int unsigned TW = 16,
   parameter int unsigned TF = TW - 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] br,
   input  logic signed [DW-1:0] bi,
   input  logic signed [TW-1:0] wr,
   input  logic signed [TW-1:0] wi,
   input  logic                 inv,
   output logic                 out_valid,
   output logic signed [DW:0]   tr,
   output logic signed [DW:0]   ti
);

   localparam int unsigned PW = DW + TW;

   logic                 v2;
   logic signed [PW-1:0] brx, bix, wrx, wix;
   logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [PW:0]   s_r, s_i;

   always_comb begin
      brx  = PW'(br);
      bix  = PW'(bi);
      wrx  = PW'(wr);
      wix  = PW'(wi);
      m_rr = brx * wrx;
      m_ii = bix * wix;
      m_ri = brx * wix;
      m_ir = bix * wrx;
   end

   // Conjugation negates the full-precision wi products, so wi = -2^(TW-1) stays exact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2   <= 1'b0;
         p_rr <= '0;
         p_ii <= '0;
         p_ri <= '0;
         p_ir <= '0;
      end else if (en) begin
         v2   <= in_valid;
         p_rr <= m_rr;
         p_ii <= inv ? -m_ii : m_ii;
         p_ri <= inv ? -m_ri : m_ri;
         p_ir <= m_ir;
      end
   end

   always_comb begin
      s_r = (PW+1)'(p_rr) - (PW+1)'(p_ii);
      s_i = (PW+1)'(p_ri) + (PW+1)'(p_ir);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         tr        <= '0;
         ti        <= '0;
      end else if (en) begin
         out_valid <= v2;
         tr        <= (DW+1)'(round_shr(wide_t'(s_r), TF));
         ti        <= (DW+1)'(round_shr(wide_t'(s_i), TF));
      end
   end

endmodule

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly X = A + B*W, Y = A - B*W with valid/ready back-pressure.
// Define BUTTERFLY_PIPE_SAT_EN to clamp out-of-range results instead of wrapping.
module butterfly_pipe
   import bfly_pkg::*;
#(
   parameter int unsigned DW   = 32,
   parameter int unsigned TW   = 16,
   parameter int unsigned TF   = TW - 1,
   parameter int unsigned TAGW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_ar,
   input  logic [DW-1:0]   in_ai,
   input  logic [DW-1:0]   in_br,
   input  logic [DW-1:0]   in_bi,
   input  logic [TW-1:0]   in_wr,
   input  logic [TW-1:0]   in_wi,
   input  logic            in_inv,
   input  logic            in_scale,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_xr,
   output logic [DW-1:0]   out_xi,
   output logic [DW-1:0]   out_yr,
   output logic [DW-1:0]   out_yi,
   output logic [TAGW-1:0] out_tag,
   output logic            ovf,
   input  logic            ovf_clr
);

`ifdef BUTTERFLY_PIPE_SAT_EN
   localparam logic SatEn = 1'b1;
`else
   localparam logic SatEn = 1'b0;
`endif

   logic                 stall, en;
   logic                 v1, v3, v4;
   logic signed [DW-1:0] ar1, ai1, br1, bi1, ar2, ai2, ar3, ai3;
   logic signed [TW-1:0] wr1, wi1;
   logic                 inv1, sc1, sc2, sc3;
   logic [TAGW-1:0]      tag1, tag2, tag3;
   logic signed [DW:0]   tr3, ti3;
   cplx_t                xs, ys;
   logic [DW-1:0]        xr_d, xi_d, yr_d, yi_d;
   logic                 hit;

   assign stall     = v4 & ~out_ready;
   assign en        = ~stall;
   assign in_ready  = en;
   assign out_valid = v4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1   <= 1'b0;
         ar1  <= '0;
         ai1  <= '0;
         br1  <= '0;
         bi1  <= '0;
         wr1  <= '0;
         wi1  <= '0;
         inv1 <= 1'b0;
         sc1  <= 1'b0;
         tag1 <= '0;
      end else if (en) begin
         v1   <= in_valid;
         ar1  <= $signed(in_ar);
         ai1  <= $signed(in_ai);
         br1  <= $signed(in_br);
         bi1  <= $signed(in_bi);
         wr1  <= $signed(in_wr);
         wi1  <= $signed(in_wi);
         inv1 <= in_inv;
         sc1  <= in_scale;
         tag1 <= in_tag;
      end
   end

   bfly_cmul #(
      .DW(DW),
      .TW(TW),
      .TF(TF)
   ) u_cmul (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_valid (v1),
      .br       (br1),
      .bi       (bi1),
      .wr       (wr1),
      .wi       (wi1),
      .inv      (inv1),
      .out_valid(v3),
      .tr       (tr3),
      .ti       (ti3)
   );

   // A, scale and tag ride alongside the two multiplier stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ar2  <= '0;
         ai2  <= '0;
         sc2  <= 1'b0;
         tag2 <= '0;
         ar3  <= '0;
         ai3  <= '0;
         sc3  <= 1'b0;
         tag3 <= '0;
      end else if (en) begin
         ar2  <= ar1;
         ai2  <= ai1;
         sc2  <= sc1;
         tag2 <= tag1;
         ar3  <= ar2;
         ai3  <= ai2;
         sc3  <= sc2;
         tag3 <= tag2;
      end
   end

   always_comb begin
      xs.re = wide_t'(ar3) + wide_t'(tr3);
      xs.im = wide_t'(ai3) + wide_t'(ti3);
      ys.re = wide_t'(ar3) - wide_t'(tr3);
      ys.im = wide_t'(ai3) - wide_t'(ti3);
      if (sc3) begin
         xs.re = round_shr(xs.re, 1);
         xs.im = round_shr(xs.im, 1);
         ys.re = round_shr(ys.re, 1);
         ys.im = round_shr(ys.im, 1);
      end
      hit  = !fits(xs.re, DW) || !fits(xs.im, DW) || !fits(ys.re, DW) || !fits(ys.im, DW);
      xr_d = DW'(reduce(xs.re, DW, SatEn));
      xi_d = DW'(reduce(xs.im, DW, SatEn));
      yr_d = DW'(reduce(ys.re, DW, SatEn));
      yi_d = DW'(reduce(ys.im, DW, SatEn));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v4      <= 1'b0;
         out_xr  <= '0;
         out_xi  <= '0;
         out_yr  <= '0;
         out_yi  <= '0;
         out_tag <= '0;
      end else if (en) begin
         v4      <= v3;
         out_xr  <= xr_d;
         out_xi  <= xi_d;
         out_yr  <= yr_d;
         out_yi  <= yi_d;
         out_tag <= tag3;
      end
   end

   // Clear wins over a same-cycle set; only real samples entering S4 can set it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end else if (en && v3 && hit) begin
         ovf <= 1'b1;
      end
   end

endmodule
